// File: rtl/shift_out_pkg.sv
// Shared state encoding and default sizing for the shift_out_tx serial display driver.
package shift_out_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_SHIFT_LO = ST_SHIFT_LO,
    S_SHIFT_HI = ST_SHIFT_HI,
    S_LATCH    = ST_LATCH
  } state_t;

endpackage

// File: rtl/phase_tick_div.sv
// Phase timer: reloads to CLK_DIV-1 on restart, counts down, and ticks on the last cycle of a phase.
module phase_tick_div
  import shift_out_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Parks at zero between phases, so a phase that is not restarted leaves it cleared.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/shift_out_tx.sv
// Parallel-to-serial driver for a 74HC595-style shift/latch chain.
// Bit order: MSB first by default; define LSB_FIRST_EN to send data_in[0] first.
//
// state      | meaning
// IDLE       | waiting for start; done pulses here for one cycle after a transfer
// SHIFT_LO   | sclk low for CLK_DIV cycles, sdata set up for the next rising edge
// SHIFT_HI   | sclk high for CLK_DIV cycles, chain samples sdata
// LATCH      | sclk low, latch high for CLK_DIV cycles, sdata holds last bit
module shift_out_tx
  import shift_out_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdata,
  output logic             latch
);

  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             load_bit;
  logic             next_bit;
  logic             tick;
  logic             div_restart;

  // Rotating rather than shifting keeps every register bit live; the wrapped bit is never sent.
`ifdef LSB_FIRST_EN
  assign load_bit  = data_in[0];
  assign shreg_nxt = {shreg[0], shreg[WIDTH-1:1]};
  assign next_bit  = shreg_nxt[0];
`else
  assign load_bit  = data_in[WIDTH-1];
  assign shreg_nxt = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
  assign next_bit  = shreg_nxt[WIDTH-1];
`endif

  // Every phase except LATCH hands off to another timed phase, so only those restart the timer.
  assign div_restart = (state == S_IDLE) ? start
                     : (((state == S_SHIFT_LO) || (state == S_SHIFT_HI)) && tick);

  phase_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .restart (div_restart),
    .tick    (tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      latch   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SHIFT_LO;
            shreg <= data_in;
            sdata <= load_bit;
            sclk  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_SHIFT_LO: begin
          if (tick) begin
            state <= S_SHIFT_HI;
            sclk  <= 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state   <= S_LATCH;
              latch   <= 1'b1;
              bit_cnt <= '0;
            end else begin
              state   <= S_SHIFT_LO;
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_nxt;
              sdata   <= next_bit;
            end
          end
        end
        S_LATCH: begin
          if (tick) begin
            state <= S_IDLE;
            latch <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
